// File: rtl/rv32i_dmem_arbiter_if.sv
// rtl/rv32i_dmem_arbiter_if.sv - CPU, loader and RAM data-port signals for the dmem arbiter
interface rv32i_dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_be;
    logic [29:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;

    logic        ldr_req;
    logic        ldr_lock;
    logic        ldr_we;
    logic [3:0]  ldr_be;
    logic [29:0] ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_gnt;
    logic        ldr_rvalid;
    logic [31:0] ldr_rdata;

    logic        memif_we;
    logic [3:0]  memif_be;
    logic [29:0] memif_addr;
    logic [31:0] memif_wdata;
    logic [31:0] memif_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  ldr_req, ldr_lock, ldr_we, ldr_be, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_rvalid, ldr_rdata,
        output memif_we, memif_be, memif_addr, memif_wdata,
        input  memif_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output ldr_req, ldr_lock, ldr_we, ldr_be, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_rvalid, ldr_rdata,
        input  memif_we, memif_be, memif_addr, memif_wdata,
        output memif_rdata
    );
endinterface

// File: rtl/rv32i_dmem_arbiter.sv
// rtl/rv32i_dmem_arbiter.sv - two-master arbiter for the data port of the dual-port RAM
module rv32i_dmem_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    rv32i_dmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        PRI_CPU = 2'd0,
        PRI_LDR = 2'd1,
        LOCK    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_nxt;
    logic              r_cpu_rvalid;
    logic              r_ldr_rvalid;

    logic              w_cpu_gnt;
    logic              w_ldr_gnt;
    logic              w_ldr_denied;
    logic              w_memif_we;
    logic [3:0]        w_memif_be;
    logic [29:0]       w_memif_addr;
    logic [31:0]       w_memif_wdata;

    // Grants are masked by reset so they drop the instant reset falls.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ldr_gnt = 1'b0;
        if (reset) begin
            case (r_state)
                PRI_CPU: begin
                    w_cpu_gnt = bus.cpu_req;
                    w_ldr_gnt = bus.ldr_req & ~bus.cpu_req;
                end
                PRI_LDR: begin
                    w_ldr_gnt = bus.ldr_req;
                    w_cpu_gnt = bus.cpu_req & ~bus.ldr_req;
                end
                LOCK: begin
                    w_ldr_gnt = bus.ldr_req;
                end
                default: ;
            endcase
        end
    end

    assign w_ldr_denied = bus.ldr_req & ~w_ldr_gnt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PRI_CPU: begin
                if (w_ldr_gnt && bus.ldr_lock)
                    w_state_nxt = LOCK;
                else if (w_ldr_denied && (r_wait_cnt == WAIT_LAST))
                    w_state_nxt = PRI_LDR;
            end
            PRI_LDR: begin
                if (w_ldr_gnt && bus.ldr_lock)
                    w_state_nxt = LOCK;
                else if (w_ldr_gnt || !bus.ldr_req)
                    w_state_nxt = PRI_CPU;
            end
            LOCK: begin
                if (!bus.ldr_req || (w_ldr_gnt && !bus.ldr_lock))
                    w_state_nxt = PRI_CPU;
            end
            default: w_state_nxt = PRI_CPU;
        endcase
    end

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (!bus.ldr_req || w_ldr_gnt ||
            ((w_state_nxt == PRI_CPU) && (r_state != PRI_CPU)))
            w_wait_nxt = '0;
        else if (r_wait_cnt != WAIT_LAST)
            w_wait_nxt = r_wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= PRI_CPU;
            r_wait_cnt   <= '0;
            r_cpu_rvalid <= 1'b0;
            r_ldr_rvalid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wait_cnt   <= w_wait_nxt;
            r_cpu_rvalid <= w_cpu_gnt & ~bus.cpu_we;
            r_ldr_rvalid <= w_ldr_gnt & ~bus.ldr_we;
        end
    end

    // Idle cycles park address/data on the CPU fields; reset zeroes everything.
    always_comb begin
        w_memif_we    = 1'b0;
        w_memif_be    = 4'h0;
        w_memif_addr  = '0;
        w_memif_wdata = '0;
        if (reset) begin
            if (w_ldr_gnt) begin
                w_memif_we    = bus.ldr_we;
                w_memif_be    = bus.ldr_be;
                w_memif_addr  = bus.ldr_addr;
                w_memif_wdata = bus.ldr_wdata;
            end else begin
                w_memif_addr  = bus.cpu_addr;
                w_memif_wdata = bus.cpu_wdata;
                if (w_cpu_gnt) begin
                    w_memif_we = bus.cpu_we;
                    w_memif_be = bus.cpu_be;
                end
            end
        end
    end

    assign bus.cpu_gnt     = w_cpu_gnt;
    assign bus.ldr_gnt     = w_ldr_gnt;
    assign bus.cpu_stall   = bus.cpu_req & ~w_cpu_gnt;
    assign bus.cpu_rvalid  = r_cpu_rvalid;
    assign bus.ldr_rvalid  = r_ldr_rvalid;
    assign bus.cpu_rdata   = bus.memif_rdata;
    assign bus.ldr_rdata   = bus.memif_rdata;
    assign bus.memif_we    = w_memif_we;
    assign bus.memif_be    = w_memif_be;
    assign bus.memif_addr  = w_memif_addr;
    assign bus.memif_wdata = w_memif_wdata;

endmodule

// File: tb/tb_rv32i_dmem_arbiter.sv
// tb/tb_rv32i_dmem_arbiter.sv - randomized and directed bench for rv32i_dmem_arbiter
module tb_rv32i_dmem_arbiter;

    localparam int MAX_WAIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rv32i_dmem_arbiter_if bus();

    rv32i_dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : (32'h5A000000 | 32'(i));
    endfunction

    // Synchronous RAM behind the data port, one-cycle read latency.
    logic [31:0] ram [64];
    always @(posedge clk) begin
        bus.memif_rdata <= ram[bus.memif_addr[5:0]];
        if (bus.memif_we)
            ram[bus.memif_addr[5:0]] = merge(ram[bus.memif_addr[5:0]], bus.memif_wdata, bus.memif_be);
    end

    // Reference model: priority derived from the count of consecutive LDR denials.
    logic [31:0] shadow [64];
    int          m_denied;
    bit          m_ldr_first, m_locked;
    bit          m_cpu_rv, m_ldr_rv, m_cpu_stalled;
    logic [31:0] m_cpu_rd, m_ldr_rd;
    logic        e_cg, e_lg, e_we;
    logic [3:0]  e_be;
    logic [29:0] e_addr;
    logic [31:0] e_wd;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_cpu_gnt",    bus.cpu_gnt, 0);
            chk("rst_ldr_gnt",    bus.ldr_gnt, 0);
            chk("rst_memif_we",   bus.memif_we, 0);
            chk("rst_memif_be",   bus.memif_be, 0);
            chk("rst_memif_addr", bus.memif_addr, 0);
            chk("rst_memif_wd",   bus.memif_wdata, 0);
            chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
            chk("rst_ldr_rvalid", bus.ldr_rvalid, 0);
            chk("rst_cpu_stall",  bus.cpu_stall, bus.cpu_req);
            m_denied = 0; m_ldr_first = 0; m_locked = 0;
            m_cpu_rv = 0; m_ldr_rv = 0; m_cpu_stalled = 0;
        end else begin
            if (m_locked) begin
                e_lg = bus.ldr_req;  e_cg = 1'b0;
            end else if (m_ldr_first) begin
                e_lg = bus.ldr_req;  e_cg = bus.cpu_req & ~bus.ldr_req;
            end else begin
                e_cg = bus.cpu_req;  e_lg = bus.ldr_req & ~bus.cpu_req;
            end
            if (e_cg) begin
                e_we = bus.cpu_we; e_be = bus.cpu_be; e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata;
            end else if (e_lg) begin
                e_we = bus.ldr_we; e_be = bus.ldr_be; e_addr = bus.ldr_addr; e_wd = bus.ldr_wdata;
            end else begin
                e_we = 1'b0; e_be = 4'h0; e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata;
            end
            chk("cpu_gnt",    bus.cpu_gnt, e_cg);
            chk("ldr_gnt",    bus.ldr_gnt, e_lg);
            chk("cpu_stall",  bus.cpu_stall, bus.cpu_req & ~e_cg);
            chk("memif_we",   bus.memif_we, e_we);
            chk("memif_be",   bus.memif_be, e_be);
            chk("memif_addr", bus.memif_addr, e_addr);
            chk("memif_wd",   bus.memif_wdata, e_wd);
            chk("cpu_rvalid", bus.cpu_rvalid, m_cpu_rv);
            chk("ldr_rvalid", bus.ldr_rvalid, m_ldr_rv);
            if (m_cpu_rv) chk("cpu_rdata", bus.cpu_rdata, m_cpu_rd);
            if (m_ldr_rv) chk("ldr_rdata", bus.ldr_rdata, m_ldr_rd);

            m_cpu_rv = e_cg & ~bus.cpu_we;
            m_ldr_rv = e_lg & ~bus.ldr_we;
            m_cpu_rd = shadow[bus.cpu_addr[5:0]];
            m_ldr_rd = shadow[bus.ldr_addr[5:0]];
            if (e_cg && bus.cpu_we)
                shadow[bus.cpu_addr[5:0]] = merge(shadow[bus.cpu_addr[5:0]], bus.cpu_wdata, bus.cpu_be);
            if (e_lg && bus.ldr_we)
                shadow[bus.ldr_addr[5:0]] = merge(shadow[bus.ldr_addr[5:0]], bus.ldr_wdata, bus.ldr_be);

            if (e_lg) begin
                m_denied = 0; m_locked = bus.ldr_lock; m_ldr_first = 0;
            end else if (!bus.ldr_req) begin
                m_denied = 0; m_locked = 0; m_ldr_first = 0;
            end else begin
                m_denied++;
                if (m_denied >= MAX_WAIT) m_ldr_first = 1;
            end
            m_cpu_stalled = bus.cpu_req & ~e_cg;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [3:0] be,
                           input logic [29:0] addr, input logic [31:0] wd);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_be = be; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    endtask

    task automatic set_ldr(input logic req, input logic lock, input logic we, input logic [3:0] be,
                           input logic [29:0] addr, input logic [31:0] wd);
        bus.ldr_req = req; bus.ldr_lock = lock; bus.ldr_we = we; bus.ldr_be = be;
        bus.ldr_addr = addr; bus.ldr_wdata = wd;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]    = init_word(i);
            shadow[i] = init_word(i);
        end
        set_cpu(0, 0, 4'h0, 30'h0, 32'h0);
        set_ldr(0, 0, 0, 4'h0, 30'h0, 32'h0);
        #2;
        chk("init_cpu_gnt",   bus.cpu_gnt, 0);
        chk("init_memif_we",  bus.memif_we, 0);
        chk("init_cpu_rvalid", bus.cpu_rvalid, 0);
        #21 reset = 1'b1;

        // single CPU read
        step(); set_cpu(1, 0, 4'hF, 30'h10, 32'h0);
        #2; chk("t1_cpu_gnt", bus.cpu_gnt, 1); chk("t1_addr", bus.memif_addr, 30'h10);
        step(); set_cpu(0, 0, 4'hF, 30'h10, 32'h0);
        #2; chk("t1_rvalid", bus.cpu_rvalid, 1); chk("t1_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        chk("t1_ldr_rvalid", bus.ldr_rvalid, 0);

        // continuous contention: CPU x4, LDR, CPU x4
        for (int i = 0; i < 9; i++) begin
            step(); set_cpu(1, 0, 4'hF, 30'h1, 32'h0); set_ldr(1, 0, 0, 4'hF, 30'h2, 32'h0);
            #2;
            chk("t2_cpu_gnt", bus.cpu_gnt, (i != 4));
            chk("t2_ldr_gnt", bus.ldr_gnt, (i == 4));
            chk("t2_stall",   bus.cpu_stall, (i == 4));
        end

        // locked LDR burst while CPU keeps requesting
        for (int j = 0; j < 4; j++) begin
            step(); set_ldr(1, (j < 3), 1, 4'b0011, 30'h20 + 30'(j), 32'h1234ABCD + 32'(j));
            #2;
            chk("t3_cpu_gnt", bus.cpu_gnt, 0);
            chk("t3_ldr_gnt", bus.ldr_gnt, 1);
            chk("t3_we",      bus.memif_we, 1);
            chk("t3_addr",    bus.memif_addr, 30'h20 + 30'(j));
        end
        step(); set_ldr(0, 0, 0, 4'h0, 30'h0, 32'h0);
        #2; chk("t3_cpu_after", bus.cpu_gnt, 1);
        step(); set_cpu(1, 0, 4'hF, 30'h20, 32'h0);

        // conflict: CPU write beats LDR read
        step(); set_cpu(1, 1, 4'hF, 30'h30, 32'hCAFEF00D); set_ldr(1, 0, 0, 4'hF, 30'h31, 32'h0);
        #2;
        chk("t4_rd20",   bus.cpu_rdata, 32'h5A00ABCD);
        chk("t4_we",     bus.memif_we, 1);
        chk("t4_addr",   bus.memif_addr, 30'h30);
        chk("t4_wdata",  bus.memif_wdata, 32'hCAFEF00D);
        chk("t4_ldr_gnt", bus.ldr_gnt, 0);
        step(); set_cpu(0, 0, 4'h0, 30'h0, 32'h0); set_ldr(0, 0, 0, 4'h0, 30'h0, 32'h0);
        #2; chk("t4_ldr_rv", bus.ldr_rvalid, 0); chk("t4_cpu_rv", bus.cpu_rvalid, 0);

        // alternating owners
        step(); set_cpu(1, 0, 4'hF, 30'h10, 32'h0);
        step(); set_cpu(0, 0, 4'hF, 30'h10, 32'h0); set_ldr(1, 0, 0, 4'hF, 30'h30, 32'h0);
        #2;
        chk("t5_cpu_rv", bus.cpu_rvalid, 1); chk("t5_ldr_rv0", bus.ldr_rvalid, 0);
        chk("t5_cpu_rd", bus.cpu_rdata, 32'hDEADBEEF);
        step(); set_ldr(0, 0, 0, 4'h0, 30'h0, 32'h0);
        #2;
        chk("t5_ldr_rv", bus.ldr_rvalid, 1); chk("t5_cpu_rv0", bus.cpu_rvalid, 0);
        chk("t5_ldr_rd", bus.ldr_rdata, 32'hCAFEF00D);

        // asynchronous reset in the middle of a lock
        step(); set_ldr(1, 1, 0, 4'hF, 30'h10, 32'h0);
        step(); set_cpu(1, 0, 4'hF, 30'h11, 32'h0); set_ldr(1, 1, 1, 4'hF, 30'h31, 32'h77);
        #1;
        chk("t6_lock_cpu", bus.cpu_gnt, 0); chk("t6_lock_ldr", bus.ldr_gnt, 1);
        chk("t6_lock_we", bus.memif_we, 1); chk("t6_lock_rv", bus.ldr_rvalid, 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_ldr", bus.ldr_gnt, 0); chk("t6_rst_cpu", bus.cpu_gnt, 0);
        chk("t6_rst_we", bus.memif_we, 0); chk("t6_rst_rv", bus.ldr_rvalid, 0);
        step();
        #2 reset = 1'b1;
        #1;
        chk("t6_rel_cpu", bus.cpu_gnt, 1); chk("t6_rel_ldr", bus.ldr_gnt, 0);
        chk("t6_rel_rv", bus.ldr_rvalid, 0);

        // randomized traffic; a stalled CPU keeps its fields
        for (int n = 0; n < 2000; n++) begin
            step();
            if (!m_cpu_stalled)
                set_cpu(($urandom % 10) < 6, $urandom % 2, 4'($urandom), 30'($urandom % 64), $urandom);
            set_ldr($urandom % 2, ($urandom % 4) == 0, $urandom % 2, 4'($urandom),
                    30'($urandom % 64), $urandom);
        end
        step();
        set_cpu(0, 0, 4'h0, 30'h0, 32'h0);
        set_ldr(0, 0, 0, 4'h0, 30'h0, 32'h0);
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv32i_dmem_arbiter.md
Name: rv32i_dmem_arbiter

Overview:
- Shares the single data port of the synchronous dual-port RAM between two requesters:
  - the pipeline memory stage (CPU);
  - a secondary loader/debug master (LDR).
- Arbitration and mux are combinational. Read-return tracking, the anti-starvation age counter and the arbitration FSM are registered.
- Sits between the memory stage and the syncDualPortRam data port. A CPU stall goes back to the pipeline whenever the CPU is denied.

Parameters:
- MAX_WAIT, 4: consecutive denied LDR cycles before LDR takes priority (legal range 1..7).
- CNT_W, 3: width of the wait counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cpu_req  input  1  CPU access request
- cpu_we  input  1  CPU write (0 = read)
- cpu_be  input  4  CPU byte enables
- cpu_addr  input  30  CPU word address [31:2]
- cpu_wdata  input  32  CPU write data
- cpu_gnt  output  1  CPU access issued this cycle
- cpu_stall  output  1  cpu_req & ~cpu_gnt
- cpu_rvalid  output  1  CPU read data valid
- cpu_rdata  output  32  CPU read data
- ldr_req  input  1  LDR access request
- ldr_lock  input  1  LDR requests exclusive ownership after this grant
- ldr_we  input  1  LDR write
- ldr_be  input  4  LDR byte enables
- ldr_addr  input  30  LDR word address
- ldr_wdata  input  32  LDR write data
- ldr_gnt  output  1  LDR access issued this cycle
- ldr_rvalid  output  1  LDR read data valid
- ldr_rdata  output  32  LDR read data
- memif_we  output  1  RAM write enable
- memif_be  output  4  RAM byte enables
- memif_addr  output  30  RAM word address
- memif_wdata  output  32  RAM write data
- memif_rdata  input  32  RAM read data (1-cycle latency)

Behaviour:
- Reset is asynchronous and active-low: clk with reset asserted low clears all state immediately.
- While reset is low:
  - state = PRI_CPU, wait_cnt = 0;
  - cpu_rvalid and ldr_rvalid are 0;
  - cpu_gnt, ldr_gnt and memif_we are forced to 0;
  - memif_be, memif_addr and memif_wdata are 0.
- An access in flight when reset falls is dropped. No rvalid is ever produced for it.
- At most one grant per cycle. A granted request is presented to the RAM in the same cycle:
  - memif_* = winner's fields;
  - memif_we = winner_we & gnt;
  - with no grant, memif_we = 0, memif_be = 0 and address/data hold the CPU fields.
- FSM states and arbitration:
  - PRI_CPU: CPU wins on conflict. A lone requester wins.
  - PRI_LDR: LDR wins on conflict. A lone requester wins.
  - LOCK: only LDR may be granted. cpu_gnt = 0 even if LDR is idle.
- FSM transitions, evaluated at the clk edge:
  - PRI_CPU -> PRI_LDR when ldr_req & ~ldr_gnt and wait_cnt == MAX_WAIT-1.
  - PRI_CPU or PRI_LDR -> LOCK when ldr_gnt & ldr_lock.
  - PRI_LDR -> PRI_CPU when ldr_gnt & ~ldr_lock, or when ~ldr_req.
  - LOCK -> PRI_CPU when ~ldr_req, or when ldr_gnt & ~ldr_lock (the final locked access).
  - LOCK stays in LOCK while ldr_req & ldr_lock.
- wait_cnt:
  - increments on ldr_req & ~ldr_gnt, saturating at MAX_WAIT-1;
  - clears on ldr_gnt, on ~ldr_req, and on any entry to PRI_CPU from another state.
- Read return:
  - cpu_rvalid <= cpu_gnt & ~cpu_we; ldr_rvalid <= ldr_gnt & ~ldr_we;
  - exactly one cycle after the grant;
  - *_rdata = memif_rdata combinationally; contents are only meaningful when the matching rvalid is high.
- Back-to-back reads from alternating owners are legal every cycle. Each rvalid follows its own grant.
- A write never produces rvalid.
- Stall: cpu_stall = cpu_req & ~cpu_gnt, combinational. The CPU holds its request fields stable while stalled.
- No requests: no grants, no rvalid the following cycle, state unchanged except the PRI_LDR/LOCK -> PRI_CPU exits listed above.

Test Plan:
- Reset released, cpu_req=1 read at addr 0x10 (RAM holds 0xDEADBEEF):
  - cpu_gnt=1 and memif_addr=0x10 that cycle;
  - next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; ldr_rvalid=0.
- cpu_req and ldr_req held high continuously, MAX_WAIT=4:
  - CPU granted cycles 0-3 and cpu_stall=0 throughout;
  - LDR granted cycle 4 with cpu_stall=1;
  - CPU granted cycles 5-8, then the pattern repeats.
- LDR write (addr 0x20, be=4'b0011, wdata=0x1234ABCD, ldr_lock=1) followed by 3 locked writes, CPU requesting throughout:
  - cpu_gnt=0 for all 4 cycles;
  - after the access with ldr_lock=0, CPU granted the next cycle.
- Same-cycle conflict in PRI_CPU with CPU write and LDR read:
  - memif_we=1 with CPU fields;
  - ldr_gnt=0 and no ldr_rvalid the next cycle.
- Alternating grants, CPU read then LDR read on consecutive cycles:
  - cpu_rvalid at cycle+1 and ldr_rvalid at cycle+2, never both high together.
- reset driven low mid-lock, between clock edges:
  - grants and memif_we drop to 0 immediately, with no clock edge required;
  - pending rvalid cleared;
  - after release, CPU wins the first conflict (state PRI_CPU, wait_cnt=0).
